obi_mem_responder: RTL and testbench
====================================

OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_STATES, default 0, range 0..15, stall cycles inserted before each grant.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_i  input  1  initiator request.
REQ-006 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port be_i  input  4  byte enables for writes.
REQ-008 SHALL have port addr_i  input  32  byte address.
REQ-009 SHALL have port wdata_i  input  32  write data.
REQ-010 SHALL have port gnt_o  output  1  request accepted this cycle.
REQ-011 SHALL have port rvalid_o  output  1  response valid.
REQ-012 SHALL have port rdata_o  output  32  read data; valid only while rvalid_o=1.
REQ-013 SHALL have port err_o  output  1  out-of-range access flag, qualified by rvalid_o.
REQ-014 SHALL have port inj_en_i  input  1  fault-injection enable.
REQ-015 SHALL have port inj_data_i  input  32  word substituted into the read response.
REQ-016 SHALL have port inj_count_o  output  8  count of injected faults, saturating at 255.

Function
REQ-017 SHALL implement FSM states IDLE, STALL, RESP, with at most one outstanding request.
REQ-018 SHALL, for WAIT_STATES=0 in IDLE or RESP with req_i=1, drive gnt_o=1 combinationally in the same cycle and enter RESP.
REQ-019 SHALL, for WAIT_STATES=N>0 in IDLE or RESP with req_i=1, keep gnt_o=0, load stall counter with N-1, and enter STALL.
REQ-020 SHALL, in STALL, decrement the counter each cycle, and drive gnt_o=1 and go to RESP when the counter is 0 and req_i=1.
REQ-021 SHALL, in STALL, return to IDLE with no grant and no response if req_i drops (abort).
REQ-022 SHALL sample we_i, be_i, addr_i and wdata_i only in the grant cycle.
REQ-023 SHALL assert rvalid_o for exactly one cycle, the cycle after each grant.
REQ-024 SHALL leave RESP for IDLE when no new request is granted or started.
REQ-025 SHALL form the word index as addr_i[31:2] and ignore addr_i[1:0].
REQ-026 SHALL treat an index >= DEPTH_WORDS as out of range: err_o=1 with rvalid_o, rdata_o=0, and any write suppressed.
REQ-027 SHALL, on an in-range write, update only the bytes whose be_i bit is 1, and return rdata_o=0 with the response.
REQ-028 SHALL, on an in-range read, return the stored word; a write granted in the previous cycle is visible to it.
REQ-029 SHALL, on a read response with inj_en_i=1 in that rvalid cycle:
  - drive rdata_o=inj_data_i;
  - increment inj_count_o, saturating at 255.
REQ-030 SHALL ignore inj_en_i on write responses, error responses, and cycles with rvalid_o=0.
REQ-031 SHALL, when a grant coincides with rvalid_o of the prior request, process both independently, giving back-to-back throughput of one access per cycle at WAIT_STATES=0.

Reset
REQ-032 SHALL, while rst_i=1:
  - force state IDLE and stall counter 0;
  - force gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, inj_count_o=0.
REQ-033 SHALL not initialise memory contents on reset; contents are preloadable by the bench.
REQ-034 SHALL, on reset mid-STALL or mid-RESP, discard the pending request with no response after reset release.

Verification
REQ-035 WAIT_STATES=0: write 0xDEADBEEF to 0x4 with be=0xF, then read 0x4 -> gnt_o in each request cycle, rvalid_o one cycle later, read returns 0xDEADBEEF with err_o=0.
REQ-036 Word at 0x8 = 0x11223344, write be=0x2 data 0xAABBCCDD, read 0x8 -> 0x1122CC44.
REQ-037 WAIT_STATES=3, read held high -> gnt_o on 4th request cycle, rvalid_o on 5th; req_i dropped at cycle 2 -> no gnt_o, no rvalid_o, state IDLE.
REQ-038 DEPTH_WORDS=256, read 0x400 -> rvalid_o=1, err_o=1, rdata_o=0; write 0x400 -> memory unchanged.
REQ-039 Read with inj_en_i=1 and inj_data_i=0x02A50533 in rvalid cycle -> rdata_o=0x02A50533, inj_count_o increments; 300 injections -> inj_count_o=255.
REQ-040 rst_i asserted during STALL, released next cycle -> all outputs 0, no stray rvalid_o, next request serviced normally.

Source files
------------

// File: rtl/obi_mem_responder.sv
// rtl/obi_mem_responder.sv - OBI-style word memory responder with wait states and read-data fault injection
module obi_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        inj_en_i,
    input  logic [31:0] inj_data_i,
    output logic [7:0]  inj_count_o
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] STALL_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, STALL, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        rvalid_q;
    logic        rd_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [7:0]  inj_cnt_q;

    logic [31:0]   word_idx;
    logic          in_range;
    logic [AW-1:0] mem_idx;
    logic          unused_addr_lsb;

    assign word_idx        = {2'b00, addr_i[31:2]};
    assign in_range        = word_idx < 32'(DEPTH_WORDS);
    assign mem_idx         = word_idx[AW-1:0];
    assign unused_addr_lsb = ^addr_i[1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (!req_i) begin
                    state_d = IDLE;
                end else if (WAIT_STATES == 0) begin
                    state_d = RESP;
                end else begin
                    state_d = STALL;
                    cnt_d   = STALL_LOAD;
                end
            end
            STALL: begin
                // A dropped request abandons the access without a response.
                if (!req_i) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        gnt_o = 1'b0;
        if (!rst_i) begin
            case (state_q)
                IDLE, RESP: gnt_o = req_i && (WAIT_STATES == 0);
                STALL:      gnt_o = req_i && (cnt_q == 4'd0);
                default:    gnt_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q  <= 1'b0;
            rd_q      <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            inj_cnt_q <= 8'd0;
        end else begin
            rvalid_q <= gnt_o;
            rd_q     <= gnt_o && !we_i && in_range;
            err_q    <= gnt_o && !in_range;
            rdata_q  <= (gnt_o && !we_i && in_range) ? mem_q[mem_idx] : 32'd0;
            if (rd_q && inj_en_i && (inj_cnt_q != 8'hFF)) begin
                inj_cnt_q <= inj_cnt_q + 8'd1;
            end
        end
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk_i) begin
        if (gnt_o && we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rvalid_o    = rvalid_q;
    assign err_o       = err_q;
    assign rdata_o     = (rd_q && inj_en_i) ? inj_data_i : rdata_q;
    assign inj_count_o = inj_cnt_q;

endmodule

// File: tb/tb_obi_mem_responder.sv
// tb/tb_obi_mem_responder.sv - self-checking bench for obi_mem_responder (zero and three wait states)
module tb_obi_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, req0, we0, inj_en0, gnt0, rvalid0, err0;
    logic [3:0]  be0;
    logic [31:0] addr0, wdata0, inj_data0, rdata0;
    logic [7:0]  inj_cnt0;

    logic        rst1, req1, we1, inj_en1, gnt1, rvalid1, err1;
    logic [3:0]  be1;
    logic [31:0] addr1, wdata1, inj_data1, rdata1;
    logic [7:0]  inj_cnt1;

    obi_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rst_i(rst0), .req_i(req0), .we_i(we0), .be_i(be0),
        .addr_i(addr0), .wdata_i(wdata0), .gnt_o(gnt0), .rvalid_o(rvalid0),
        .rdata_o(rdata0), .err_o(err0), .inj_en_i(inj_en0),
        .inj_data_i(inj_data0), .inj_count_o(inj_cnt0)
    );

    obi_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) dut1 (
        .clk_i(clk), .rst_i(rst1), .req_i(req1), .we_i(we1), .be_i(be1),
        .addr_i(addr1), .wdata_i(wdata1), .gnt_o(gnt1), .rvalid_o(rvalid1),
        .rdata_o(rdata1), .err_o(err1), .inj_en_i(inj_en1),
        .inj_data_i(inj_data1), .inj_count_o(inj_cnt1)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: plain word array plus the one response in flight.
    logic [31:0] model_mem [256];
    bit          pend_v, pend_rd, pend_err;
    logic [31:0] pend_d;
    int          exp_cnt;
    logic [31:0] obs_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step0(input bit r, input bit w, input logic [3:0] be, input logic [31:0] a,
                         input logic [31:0] wd, input bit ie, input logic [31:0] id);
        int unsigned idx;
        @(posedge clk);
        #1;
        req0 = r; we0 = w; be0 = be; addr0 = a; wdata0 = wd; inj_en0 = ie; inj_data0 = id;
        @(negedge clk);
        chk("gnt0", {31'd0, gnt0}, {31'd0, r});
        chk("rvalid0", {31'd0, rvalid0}, {31'd0, pend_v});
        chk("inj_count0", {24'd0, inj_cnt0}, exp_cnt);
        if (pend_v) begin
            obs_rdata = rdata0;
            chk("err0", {31'd0, err0}, {31'd0, pend_err});
            chk("rdata0", rdata0, (pend_rd && ie) ? id : pend_d);
            if (pend_rd && ie && exp_cnt < 255) exp_cnt++;
        end
        pend_v = r;
        if (r) begin
            idx = a[31:2];
            pend_err = (idx >= 256);
            pend_rd  = !pend_err && !w;
            pend_d   = 32'd0;
            if (!pend_err) begin
                if (w) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    pend_d = model_mem[idx];
                end
            end
        end
    endtask

    task automatic cyc1(input bit r, input bit w, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        req1 = r; we1 = w; be1 = 4'hF; addr1 = a; wdata1 = wd;
        @(negedge clk);
    endtask

    task automatic ws3_txn(input bit w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input string tag);
        for (int k = 1; k <= 4; k++) begin
            cyc1(1'b1, w, a, wd);
            chk({tag, "_gnt"}, {31'd0, gnt1}, (k == 4) ? 32'd1 : 32'd0);
            chk({tag, "_rvalid_early"}, {31'd0, rvalid1}, 32'd0);
        end
        cyc1(1'b0, 1'b0, 32'd0, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, rvalid1}, 32'd1);
        chk({tag, "_err"}, {31'd0, err1}, 32'd0);
        chk({tag, "_rdata"}, rdata1, exp_rd);
    endtask

    initial begin
        logic [31:0] a;
        int unsigned idx;
        pend_v = 0; pend_rd = 0; pend_err = 0; pend_d = 0; exp_cnt = 0; obs_rdata = 0;
        rst0 = 1; req0 = 1; we0 = 0; be0 = 0; addr0 = 0; wdata0 = 0; inj_en0 = 1; inj_data0 = 32'hFFFF_FFFF;
        rst1 = 1; req1 = 1; we1 = 0; be1 = 0; addr1 = 0; wdata1 = 0; inj_en1 = 0; inj_data1 = 0;
        #2;
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_err0", {31'd0, err0}, 32'd0);
        chk("rst_inj0", {24'd0, inj_cnt0}, 32'd0);
        chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
        req0 = 0; req1 = 0; inj_en0 = 0;
        @(posedge clk);
        #1;
        rst0 = 0; rst1 = 0;

        for (int i = 0; i < 16; i++) step0(1, 1, 4'hF, 32'(i * 4), $urandom, 0, 0);

        step0(1, 1, 4'hF, 32'h4, 32'hDEADBEEF, 0, 0);
        step0(1, 0, 4'h0, 32'h4, 32'h0, 0, 0);
        step0(0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
        chk("deadbeef", obs_rdata, 32'hDEADBEEF);

        step0(1, 1, 4'hF, 32'h8, 32'h11223344, 0, 0);
        step0(1, 1, 4'h2, 32'h8, 32'hAABBCCDD, 0, 0);
        step0(1, 0, 4'h0, 32'hB, 32'h0, 0, 0);
        step0(0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
        chk("byte_en", obs_rdata, 32'h1122CC44);

        step0(1, 1, 4'hF, 32'h0, 32'h0BADF00D, 0, 0);
        step0(1, 1, 4'hF, 32'h400, 32'hFFFFFFFF, 0, 0);
        step0(1, 0, 4'h0, 32'h400, 32'h0, 1, 32'h12345678);
        step0(1, 0, 4'h0, 32'h0, 32'h0, 1, 32'h12345678);
        step0(0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
        chk("oor_write_suppressed", obs_rdata, 32'h0BADF00D);

        step0(1, 0, 4'h0, 32'h4, 32'h0, 0, 0);
        step0(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h02A50533);
        chk("inject", obs_rdata, 32'h02A50533);

        for (int i = 0; i < 400; i++) begin
            idx = ($urandom_range(0, 9) == 0) ? 256 + $urandom_range(0, 1000) : $urandom_range(0, 15);
            a = {idx[29:0], 2'($urandom)};
            step0($urandom_range(0, 9) < 7, 1'($urandom), 4'($urandom), a, $urandom,
                  $urandom_range(0, 2) == 0, $urandom);
        end

        for (int i = 0; i < 300; i++) step0(1, 0, 4'h0, 32'h4, 32'h0, 1, 32'h02A50533);
        step0(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h02A50533);
        step0(0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
        chk("inj_saturate", {24'd0, inj_cnt0}, 32'd255);

        ws3_txn(1, 32'h10, 32'h5A5A1234, 32'h0, "ws3_wr");
        ws3_txn(0, 32'h10, 32'h0, 32'h5A5A1234, "ws3_rd");

        cyc1(1, 0, 32'h10, 32'h0);
        chk("abort_gnt_a", {31'd0, gnt1}, 32'd0);
        cyc1(0, 0, 32'h10, 32'h0);
        chk("abort_gnt_b", {31'd0, gnt1}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc1(0, 0, 32'h0, 32'h0);
            chk("abort_rvalid", {31'd0, rvalid1}, 32'd0);
        end
        ws3_txn(0, 32'h10, 32'h0, 32'h5A5A1234, "ws3_after_abort");

        cyc1(1, 0, 32'h10, 32'h0);
        cyc1(1, 0, 32'h10, 32'h0);
        rst1 = 1;
        #1;
        chk("rst_stall_gnt", {31'd0, gnt1}, 32'd0);
        chk("rst_stall_rvalid", {31'd0, rvalid1}, 32'd0);
        chk("rst_stall_rdata", rdata1, 32'd0);
        chk("rst_stall_err", {31'd0, err1}, 32'd0);
        chk("rst_stall_inj", {24'd0, inj_cnt1}, 32'd0);
        @(posedge clk);
        #1;
        rst1 = 0; req1 = 0;
        for (int i = 0; i < 4; i++) begin
            cyc1(0, 0, 32'h0, 32'h0);
            chk("post_rst_rvalid", {31'd0, rvalid1}, 32'd0);
            chk("post_rst_gnt", {31'd0, gnt1}, 32'd0);
        end
        ws3_txn(0, 32'h10, 32'h0, 32'h5A5A1234, "ws3_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
